// File: rtl/sram_bitstream_reader_if.sv
// Bus bundle between the bitstream reader, its SRAM read port and the
// downstream decoder. The reader is the slave; the controller/environment
// side (start/stop, SRAM data return, decoder consume) is the master.
interface sram_bitstream_reader_if;
  logic        Start;
  logic        Stop;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [15:0] Bits_window;
  logic [5:0]  Bits_avail;
  logic        Bits_valid;
  logic [4:0]  Bits_consume;
  logic        Busy;

  modport slave (
    input  Start, Stop, SRAM_read_data, Bits_consume,
    output SRAM_address, SRAM_we_n, Bits_window, Bits_avail, Bits_valid, Busy
  );

  modport master (
    output Start, Stop, SRAM_read_data, Bits_consume,
    input  SRAM_address, SRAM_we_n, Bits_window, Bits_avail, Bits_valid, Busy
  );
endinterface

// File: rtl/sram_bitstream_reader.sv
// SRAM bitstream reader: prefetches 16-bit words from SRAM into a 48-bit
// MSB-aligned bit buffer and exposes the oldest 16 bits to the decoder,
// which may drop 0..16 bits per cycle.
//
// The valid pipe has READ_LATENCY+1 stages: bit 0 marks the cycle the
// address is on the bus, bit READ_LATENCY marks the cycle its data is on
// SRAM_read_data (appended at the end of that cycle). Every stage counts as
// in flight, so the issue check reserves room for all of them.
module sram_bitstream_reader #(
  parameter logic [17:0] START_ADDRESS = 18'd76800,
  parameter logic [17:0] END_ADDRESS   = 18'h3FFFF,
  parameter int          READ_LATENCY  = 3
) (
  input logic                    Clock,
  input logic                    Resetn,
  sram_bitstream_reader_if.slave bus
);
  localparam int STAGES = READ_LATENCY;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [17:0]     r_next_addr;
  logic [17:0]     r_addr;
  logic [47:0]     r_buf;
  logic [5:0]      r_avail;
  logic [STAGES:0] r_vld_pipe;

  logic [2:0]      w_inflight;
  logic [6:0]      w_inflight_bits;
  logic [7:0]      w_need;
  logic            w_issue;
  logic            w_restart;
  logic            w_clear;
  logic [5:0]      w_k;
  logic [5:0]      w_kept;
  logic [47:0]     w_shifted;
  logic [47:0]     w_word_pos;

  // Count words in flight across all pipe stages.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= STAGES; i++) w_inflight = w_inflight + 3'(r_vld_pipe[i]);
  end

  assign w_inflight_bits = {w_inflight, 4'b0000};
  // Occupancy once every in-flight word and one more have landed (pre-consume).
  assign w_need = {2'b00, r_avail} + {1'b0, w_inflight_bits} + 8'd16;

  // Consume is all-or-nothing: oversize or over-avail requests count as zero.
  assign w_k = (bus.Bits_consume <= 5'd16 && {1'b0, bus.Bits_consume} <= r_avail)
             ? {1'b0, bus.Bits_consume} : 6'd0;
  assign w_kept     = r_avail - w_k;
  assign w_shifted  = r_buf << w_k;
  // Returning word lands right behind the bits that survive this cycle's consume.
  assign w_word_pos = {bus.SRAM_read_data, 32'h0} >> w_kept;

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and issue control; Start beats Stop, both beat normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_restart   = 1'b0;
    w_clear     = 1'b0;
    if (bus.Start) begin
      // The start edge itself issues START_ADDRESS.
      w_restart   = 1'b1;
      w_clear     = 1'b1;
      w_state_nxt = (START_ADDRESS == END_ADDRESS) ? S_DRAIN : S_FETCH;
    end else if (bus.Stop) begin
      w_clear     = 1'b1;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_need <= 8'd48) begin
            w_issue = 1'b1;
            if (r_next_addr == END_ADDRESS) w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Only the tail (appending now) may remain; Busy drops right after.
          if (r_vld_pipe[STAGES-1:0] == '0) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Address, read pipe and bit buffer; consume and append share one edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_addr      <= '0;
      r_next_addr <= '0;
      r_buf       <= '0;
      r_avail     <= '0;
      r_vld_pipe  <= '0;
    end else if (w_clear) begin
      r_buf      <= '0;
      r_avail    <= '0;
      r_vld_pipe <= {{STAGES{1'b0}}, w_restart};
      if (w_restart) begin
        r_addr      <= START_ADDRESS;
        r_next_addr <= START_ADDRESS + 18'd1;
      end
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_issue};
      if (w_issue) begin
        r_addr      <= r_next_addr;
        r_next_addr <= r_next_addr + 18'd1;
      end
      if (r_vld_pipe[STAGES]) begin
        r_buf   <= w_shifted | w_word_pos;
        r_avail <= w_kept + 6'd16;
      end else begin
        r_buf   <= w_shifted;
        r_avail <= w_kept;
      end
    end
  end

  assign bus.SRAM_address = r_addr;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.Bits_window  = r_buf[47:32];
  assign bus.Bits_avail   = r_avail;
  assign bus.Bits_valid   = (r_avail >= 6'd16);
  assign bus.Busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_sram_bitstream_reader.sv
module tb_sram_bitstream_reader;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clock = ~Clock;

  sram_bitstream_reader_if bus1();
  sram_bitstream_reader_if bus2();

  sram_bitstream_reader u_dut1 (.Clock(Clock), .Resetn(Resetn), .bus(bus1));
  sram_bitstream_reader #(.START_ADDRESS(18'h3FFFE)) u_dut2 (.Clock(Clock), .Resetn(Resetn), .bus(bus2));

  // SRAM contents: a few fixed words, distinct pseudo-random elsewhere.
  function automatic logic [15:0] mem_word(input logic [17:0] a);
    case (a)
      18'd76800: return 16'hA5C3;
      18'd76801: return 16'h0F0F;
      18'd76802: return 16'h1234;
      18'h3FFFE: return 16'hBEEF;
      18'h3FFFF: return 16'hCAFE;
      default:   return 16'((32'(a) * 32'd40503) ^ 32'h5A5A);
    endcase
  endfunction

  // SRAM model with 3-cycle read latency.
  logic [2:0][17:0] hist1 = '0;
  logic [2:0][17:0] hist2 = '0;
  always @(posedge Clock) begin
    hist1 <= {hist1[1:0], bus1.SRAM_address};
    hist2 <= {hist2[1:0], bus2.SRAM_address};
  end
  assign bus1.SRAM_read_data = mem_word(hist1[2]);
  assign bus2.SRAM_read_data = mem_word(hist2[2]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic [4:0]  consume;
    logic [15:0] win;
    logic [5:0]  avail;
    logic        valid;
    logic        busy;
    logic [17:0] addr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int got;
    int max_av;
    // cycle-by-cycle after Start (row 0 = cycle 1); consume applied that cycle
    tbl[0]  = '{5'd0,  16'h0000, 6'd0,  1'b0, 1'b1, 18'd76800};
    tbl[1]  = '{5'd0,  16'h0000, 6'd0,  1'b0, 1'b1, 18'd76801};
    tbl[2]  = '{5'd0,  16'h0000, 6'd0,  1'b0, 1'b1, 18'd76802};
    tbl[3]  = '{5'd0,  16'h0000, 6'd0,  1'b0, 1'b1, 18'd76802};
    tbl[4]  = '{5'd0,  16'hA5C3, 6'd16, 1'b1, 1'b1, 18'd76802};
    tbl[5]  = '{5'd0,  16'hA5C3, 6'd32, 1'b1, 1'b1, 18'd76802};
    tbl[6]  = '{5'd3,  16'hA5C3, 6'd48, 1'b1, 1'b1, 18'd76802};
    tbl[7]  = '{5'd16, 16'h2E18, 6'd45, 1'b1, 1'b1, 18'd76802};
    tbl[8]  = '{5'd0,  16'h7878, 6'd29, 1'b1, 1'b1, 18'd76802};
    tbl[9]  = '{5'd17, 16'h7878, 6'd29, 1'b1, 1'b1, 18'd76803};
    tbl[10] = '{5'd29, 16'h7878, 6'd29, 1'b1, 1'b1, 18'd76803};
    tbl[11] = '{5'd0,  16'h7878, 6'd29, 1'b1, 1'b1, 18'd76803};
    tbl[12] = '{5'd0,  16'h7878, 6'd29, 1'b1, 1'b1, 18'd76803};
    tbl[13] = '{5'd0,  16'h7878, 6'd45, 1'b1, 1'b1, 18'd76803};

    bus1.Start = 0; bus1.Stop = 0; bus1.Bits_consume = 0;
    bus2.Start = 0; bus2.Stop = 0; bus2.Bits_consume = 0;

    // reset values
    step(); step();
    chk("rst_addr",  32'(bus1.SRAM_address), 0);
    chk("rst_we_n",  32'(bus1.SRAM_we_n), 1);
    chk("rst_win",   32'(bus1.Bits_window), 0);
    chk("rst_avail", 32'(bus1.Bits_avail), 0);
    chk("rst_valid", 32'(bus1.Bits_valid), 0);
    chk("rst_busy",  32'(bus1.Busy), 0);
    Resetn = 1'b1;
    step();

    // table-driven run from Start
    bus1.Start = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      bus1.Start = 0;
      chk($sformatf("c%0d_win", i+1),   32'(bus1.Bits_window), 32'(tbl[i].win));
      chk($sformatf("c%0d_avail", i+1), 32'(bus1.Bits_avail),  32'(tbl[i].avail));
      chk($sformatf("c%0d_valid", i+1), 32'(bus1.Bits_valid),  32'(tbl[i].valid));
      chk($sformatf("c%0d_busy", i+1),  32'(bus1.Busy),        32'(tbl[i].busy));
      chk($sformatf("c%0d_addr", i+1),  32'(bus1.SRAM_address), 32'(tbl[i].addr));
      chk($sformatf("c%0d_we_n", i+1),  32'(bus1.SRAM_we_n), 1);
      bus1.Bits_consume = tbl[i].consume;
    end
    bus1.Bits_consume = 0;

    // restart while 3 reads are in flight: stale words must never land
    bus1.Start = 1;
    step(); bus1.Start = 0;       // cycle 1
    step(); step();               // cycle 3
    bus1.Start = 1;               // restart at edge 3
    step(); bus1.Start = 0;       // new cycle 1
    chk("rs_addr1", 32'(bus1.SRAM_address), 32'd76800);
    chk("rs_avail1", 32'(bus1.Bits_avail), 0);
    step();                        // new cycle 2
    chk("rs_avail2", 32'(bus1.Bits_avail), 0);
    step(); step();                // new cycle 4
    chk("rs_avail4", 32'(bus1.Bits_avail), 0);
    chk("rs_win4", 32'(bus1.Bits_window), 0);
    step();                        // new cycle 5
    chk("rs_win5", 32'(bus1.Bits_window), 32'hA5C3);
    chk("rs_avail5", 32'(bus1.Bits_avail), 16);

    // stream 64 words at up to 16 bits/cycle, stalling on Bits_valid
    got = 0;
    max_av = 0;
    for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
      if (int'(bus1.Bits_avail) > max_av) max_av = int'(bus1.Bits_avail);
      if (bus1.Bits_valid) begin
        chk($sformatf("stream_w%0d", got), 32'(bus1.Bits_window),
            32'(mem_word(18'(32'd76800 + 32'(got)))));
        got++;
        bus1.Bits_consume = 5'd16;
      end else begin
        bus1.Bits_consume = 5'd0;
      end
      step();
    end
    bus1.Bits_consume = 0;
    chk("stream_count", 32'(got), 64);
    chk("stream_avail_over48", 32'(max_av > 48), 0);

    // Stop clears everything and idles
    bus1.Stop = 1;
    step(); bus1.Stop = 0;
    chk("stop_avail", 32'(bus1.Bits_avail), 0);
    chk("stop_win",   32'(bus1.Bits_window), 0);
    chk("stop_valid", 32'(bus1.Bits_valid), 0);
    chk("stop_busy",  32'(bus1.Busy), 0);

    // short run at the top of memory: 2 reads, drain, idle, bits remain
    bus2.Start = 1;
    step(); bus2.Start = 0;       // cycle 1
    chk("top_addr1", 32'(bus2.SRAM_address), 32'h3FFFE);
    chk("top_busy1", 32'(bus2.Busy), 1);
    step();                        // cycle 2
    chk("top_addr2", 32'(bus2.SRAM_address), 32'h3FFFF);
    step();                        // cycle 3
    chk("top_addr3", 32'(bus2.SRAM_address), 32'h3FFFF);
    chk("top_busy3", 32'(bus2.Busy), 1);
    step(); step();                // cycle 5
    chk("top_win5", 32'(bus2.Bits_window), 32'hBEEF);
    chk("top_avail5", 32'(bus2.Bits_avail), 16);
    step(); step(); step();        // cycle 8
    chk("top_busy8", 32'(bus2.Busy), 0);
    chk("top_avail8", 32'(bus2.Bits_avail), 32);
    chk("top_addr8", 32'(bus2.SRAM_address), 32'h3FFFF);
    bus2.Bits_consume = 16;
    step();
    chk("top_win_c16", 32'(bus2.Bits_window), 32'hCAFE);
    chk("top_av_c16", 32'(bus2.Bits_avail), 16);
    bus2.Bits_consume = 11;
    step();
    chk("top_win_c11", 32'(bus2.Bits_window), 32'hF000);
    chk("top_av_c11", 32'(bus2.Bits_avail), 5);
    bus2.Bits_consume = 7;         // more than available: ignored
    step();
    chk("ign7_avail", 32'(bus2.Bits_avail), 5);
    chk("ign7_win", 32'(bus2.Bits_window), 32'hF000);
    bus2.Bits_consume = 17;        // over 16: ignored
    step();
    chk("ign17_avail", 32'(bus2.Bits_avail), 5);
    bus2.Bits_consume = 5;
    step();
    bus2.Bits_consume = 0;
    chk("drain_avail", 32'(bus2.Bits_avail), 0);
    chk("drain_win", 32'(bus2.Bits_window), 0);
    chk("drain_valid", 32'(bus2.Bits_valid), 0);

    // asynchronous reset mid-run
    bus1.Start = 1;
    step(); bus1.Start = 0;
    repeat (5) step();             // cycle 6, avail 32
    chk("pre_rst_avail", 32'(bus1.Bits_avail), 32);
    #2 Resetn = 1'b0;
    #1;
    chk("arst_addr",  32'(bus1.SRAM_address), 0);
    chk("arst_win",   32'(bus1.Bits_window), 0);
    chk("arst_avail", 32'(bus1.Bits_avail), 0);
    chk("arst_valid", 32'(bus1.Bits_valid), 0);
    chk("arst_busy",  32'(bus1.Busy), 0);
    chk("arst_we_n",  32'(bus1.SRAM_we_n), 1);
    step();
    Resetn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
